// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and codeword layout for the SECDED memory engine
package hamming_pkg;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAPT,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_SEC = 2'b01;
    localparam logic [1:0] F_DED = 2'b10;

    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    // Codeword positions whose index has bit 0/1/2/3 set; each Hamming parity covers one set.
    localparam logic [15:0] P1_MASK = 16'hAAAA;
    localparam logic [15:0] P2_MASK = 16'hCCCC;
    localparam logic [15:0] P4_MASK = 16'hF0F0;
    localparam logic [15:0] P8_MASK = 16'hFF00;

endpackage

// File: rtl/secded_codec.sv
// rtl/secded_codec.sv - combinational Hamming(16,11) SECDED encoder and decoder
module secded_codec
    import hamming_pkg::*;
(
    input  logic [10:0] data_in,
    input  logic [15:0] cw_in,
    output logic [15:0] cw_out,
    output logic [10:0] data_out,
    output logic [1:0]  flags
);

    logic [15:0] body;
    logic [3:0]  syn;
    logic        par;
    logic [10:0] flip;

    always_comb begin
        body       = '0;
        body[15:9] = data_in[10:4];
        body[7:5]  = data_in[3:1];
        body[3]    = data_in[0];
        cw_out         = body;
        cw_out[P1_POS] = ^(body & P1_MASK);
        cw_out[P2_POS] = ^(body & P2_MASK);
        cw_out[P4_POS] = ^(body & P4_MASK);
        cw_out[P8_POS] = ^(body & P8_MASK);
        cw_out[P0_POS] = ^cw_out[15:1];
    end

    // A syndrome naming a parity position (or zero) corrects no data bit, so only data positions are matched.
    always_comb begin
        syn  = {^(cw_in & P8_MASK), ^(cw_in & P4_MASK), ^(cw_in & P2_MASK), ^(cw_in & P1_MASK)};
        par  = ^cw_in;
        flip = {syn == 4'd15, syn == 4'd14, syn == 4'd13, syn == 4'd12,
                syn == 4'd11, syn == 4'd10, syn == 4'd9,  syn == 4'd7,
                syn == 4'd6,  syn == 4'd5,  syn == 4'd3};
        data_out = {cw_in[15:9], cw_in[7:5], cw_in[3]};
        if (par) begin
            data_out = data_out ^ flip;
            flags    = F_SEC;
        end else if (syn != 4'd0) begin
            flags = F_DED;
        end else begin
            flags = F_OK;
        end
    end

endmodule

// File: rtl/secded_mem_engine.sv
// rtl/secded_mem_engine.sv - memory-mastering SECDED encode/decode engine with Start/Ack handshake
module secded_mem_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG = 15,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = $clog2(NUM_MSG + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] SrcBase,
    input  logic [ADDR_W-1:0] DstBase,
    output logic              Ack,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [7:0]        MemWrData,
    input  logic [7:0]        MemRdData,
    output logic [CNT_W-1:0]  SingleCnt,
    output logic [CNT_W-1:0]  DoubleCnt
);

    localparam int IDX_W = $clog2(NUM_MSG + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);

    state_t            state;
    mode_t             mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        lo_q;
    logic [7:0]        res_hi;
    logic [ADDR_W-1:0] rec_off;

    logic [15:0] cw_enc;
    logic [10:0] dec_data;
    logic [1:0]  dec_flags;
    logic [7:0]  res_lo_c;
    logic [7:0]  res_hi_c;

    assign rec_off = ADDR_W'(idx) << 1;

    // During CAPT the high byte is on MemRdData, so the codec sees the whole record that cycle.
    secded_codec u_codec (
        .data_in  ({MemRdData[2:0], lo_q}),
        .cw_in    ({MemRdData, lo_q}),
        .cw_out   (cw_enc),
        .data_out (dec_data),
        .flags    (dec_flags)
    );

    always_comb begin
        if (mode == ENC) begin
            {res_hi_c, res_lo_c} = cw_enc;
        end else begin
            {res_hi_c, res_lo_c} = {dec_flags, 3'b000, dec_data};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            mode      <= ENC;
            src       <= '0;
            dst       <= '0;
            idx       <= '0;
            lo_q      <= '0;
            res_hi    <= '0;
            Ack       <= 1'b0;
            Busy      <= 1'b0;
            MemAddr   <= '0;
            MemWe     <= 1'b0;
            MemWrData <= '0;
            SingleCnt <= '0;
            DoubleCnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        mode      <= mode_t'(Mode);
                        src       <= SrcBase;
                        dst       <= DstBase;
                        idx       <= '0;
                        SingleCnt <= '0;
                        DoubleCnt <= '0;
                        Busy      <= 1'b1;
                        Ack       <= 1'b0;
                        MemWe     <= 1'b0;
                        MemAddr   <= SrcBase;
                        state     <= RD_LO;
                    end
                end
                RD_LO: begin
                    MemAddr <= src + rec_off + ADDR_W'(1);
                    state   <= RD_HI;
                end
                RD_HI: begin
                    lo_q  <= MemRdData;
                    state <= CAPT;
                end
                CAPT: begin
                    res_hi    <= res_hi_c;
                    MemWrData <= res_lo_c;
                    MemAddr   <= dst + rec_off;
                    MemWe     <= 1'b1;
                    if (mode == DEC) begin
                        if (dec_flags == F_SEC && SingleCnt != '1) begin
                            SingleCnt <= SingleCnt + 1'b1;
                        end
                        if (dec_flags == F_DED && DoubleCnt != '1) begin
                            DoubleCnt <= DoubleCnt + 1'b1;
                        end
                    end
                    state <= WR_LO;
                end
                WR_LO: begin
                    MemWrData <= res_hi;
                    MemAddr   <= dst + rec_off + ADDR_W'(1);
                    state     <= WR_HI;
                end
                WR_HI: begin
                    MemWe <= 1'b0;
                    if (idx == LAST_IDX) begin
                        Busy  <= 1'b0;
                        Ack   <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        MemAddr <= src + rec_off + ADDR_W'(2);
                        state   <= RD_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secded_mem_engine.sv
// tb/tb_secded_mem_engine.sv - self-checking bench for secded_mem_engine against a behavioural SECDED model
module tb_secded_mem_engine;

    localparam int NUM_MSG = 15;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 4;

    logic              Clk     = 1'b0;
    logic              Reset   = 1'b1;
    logic              Start   = 1'b0;
    logic              Mode    = 1'b0;
    logic [ADDR_W-1:0] SrcBase = '0;
    logic [ADDR_W-1:0] DstBase = '0;
    logic              Ack;
    logic              Busy;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemWe;
    logic [7:0]        MemWrData;
    logic [7:0]        MemRdData;
    logic [CNT_W-1:0]  SingleCnt;
    logic [CNT_W-1:0]  DoubleCnt;

    always #5 Clk = ~Clk;

    secded_mem_engine #(.NUM_MSG(NUM_MSG), .ADDR_W(ADDR_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .SrcBase   (SrcBase),
        .DstBase   (DstBase),
        .Ack       (Ack),
        .Busy      (Busy),
        .MemAddr   (MemAddr),
        .MemWe     (MemWe),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData),
        .SingleCnt (SingleCnt),
        .DoubleCnt (DoubleCnt)
    );

    logic [7:0] mem [256];
    int         wcount [256];
    logic       tb_we   = 1'b0;
    logic [7:0] tb_addr = '0;
    logic [7:0] tb_data = '0;
    logic       tb_clr  = 1'b0;

    always @(posedge Clk) begin
        MemRdData <= mem[MemAddr];
        if (tb_clr) begin
            for (int a = 0; a < 256; a++) wcount[a] <= 0;
        end else if (MemWe) begin
            wcount[MemAddr] <= wcount[MemAddr] + 1;
        end
        if (MemWe) mem[MemAddr] <= MemWrData;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_single;
    int exp_double;
    logic [15:0] dec_words [NUM_MSG];

    function automatic logic [15:0] ref_encode(input int d);
        int cw = 0;
        int k  = 0;
        int p;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (((d >> k) & 1) != 0) cw |= (1 << pos);
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            p = 0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) != 0 && ((cw >> pos) & 1) != 0) p ^= 1;
            if (p != 0) cw |= (1 << (1 << b));
        end
        p = 0;
        for (int pos = 1; pos < 16; pos++) if (((cw >> pos) & 1) != 0) p ^= 1;
        cw |= p;
        return 16'(cw);
    endfunction

    function automatic logic [15:0] ref_decode(input int cw);
        int s = 0;
        int par = 0;
        int f;
        int d = 0;
        int k = 0;
        for (int pos = 0; pos < 16; pos++) begin
            if (((cw >> pos) & 1) != 0) begin
                par ^= 1;
                s ^= pos;
            end
        end
        if (par != 0) begin
            cw ^= (1 << s);
            f = 1;
        end else if (s != 0) begin
            f = 2;
        end else begin
            f = 0;
        end
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (((cw >> pos) & 1) != 0) d |= (1 << k);
                k++;
            end
        end
        return 16'(((f << 14) | (d >> 8) << 8) | (d & 255));
    endfunction

    function automatic logic [15:0] inject(input logic [15:0] cw, input int n);
        int a;
        int b;
        if (n == 0) return cw;
        a  = $urandom_range(0, 15);
        cw = cw ^ (16'(1) << a);
        if (n == 2) begin
            b = $urandom_range(0, 15);
            while (b == a) b = $urandom_range(0, 15);
            cw = cw ^ (16'(1) << b);
        end
        return cw;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_run(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input int stray, output int cyc);
        Mode    = m;
        SrcBase = s;
        DstBase = d;
        Start   = 1'b1;
        tick();
        Mode    = ~m;
        SrcBase = 8'($urandom);
        DstBase = 8'($urandom);
        Start   = 1'b0;
        cyc = 1;
        while (!Ack && cyc < 200) begin
            Start = (cyc == stray);
            tick();
            cyc++;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        Reset   = 1'b1;
        Start   = 1'b1;
        Mode    = 1'b1;
        SrcBase = 8'h55;
        tick();
        tick();
        n_cmp++;
        if ({Ack, Busy, MemWe} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000", {Ack, Busy, MemWe});
        end
        n_cmp++;
        if ({MemAddr, MemWrData, SingleCnt, DoubleCnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {MemAddr, MemWrData, SingleCnt, DoubleCnt});
        end
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: got busy %b want 0", Busy);
        end
    endtask

    task automatic test_encode;
        logic [15:0] raw [NUM_MSG];
        logic [15:0] e;
        int cyc;
        raw[0] = 16'h0000;
        raw[1] = 16'hFFFF;
        for (int i = 2; i < NUM_MSG; i++) raw[i] = 16'($urandom);
        for (int i = 0; i < NUM_MSG; i++) begin
            load(8'(2 * i), raw[i][7:0]);
            load(8'(2 * i + 1), raw[i][15:8]);
        end
        do_run(1'b0, 8'd0, 8'd30, 0, cyc);
        n_cmp++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL enc_ack_latency: got %0d want 76", cyc);
        end
        n_cmp++;
        if ({mem[30], mem[31], mem[32], mem[33]} !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL enc_edges: got %h want 0000ffff", {mem[30], mem[31], mem[32], mem[33]});
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            e = ref_encode(int'(raw[i] & 16'h07FF));
            n_cmp++;
            if ({mem[8'(31 + 2 * i)], mem[8'(30 + 2 * i)]} !== e) begin
                n_fail++;
                $display("FAIL enc_rec%0d: got %h want %h", i, {mem[8'(31 + 2 * i)], mem[8'(30 + 2 * i)]}, e);
            end
        end
        n_cmp++;
        if ({SingleCnt, DoubleCnt} !== 8'h00) begin
            n_fail++;
            $display("FAIL enc_counters: got %h want 00", {SingleCnt, DoubleCnt});
        end
    endtask

    task automatic check_decoded(input string tag, input logic [7:0] d);
        logic [15:0] e;
        for (int i = 0; i < NUM_MSG; i++) begin
            e = ref_decode(int'(dec_words[i]));
            n_cmp++;
            if ({mem[8'(d + 8'(2 * i + 1))], mem[8'(d + 8'(2 * i))]} !== e) begin
                n_fail++;
                $display("FAIL %s_rec%0d: got %h want %h", tag, i,
                         {mem[8'(d + 8'(2 * i + 1))], mem[8'(d + 8'(2 * i))]}, e);
            end
        end
        n_cmp++;
        if (SingleCnt !== 4'(exp_single) || DoubleCnt !== 4'(exp_double)) begin
            n_fail++;
            $display("FAIL %s_counters: got %0d/%0d want %0d/%0d", tag, SingleCnt, DoubleCnt, exp_single, exp_double);
        end
    endtask

    task automatic test_decode;
        logic [7:0] hi_want [4];
        int cyc;
        int n;
        hi_want = '{8'h07, 8'h47, 8'h47, 8'h87};
        dec_words[0] = 16'hFFFF;
        dec_words[1] = 16'hFFFE;
        dec_words[2] = 16'hFDFF;
        dec_words[3] = 16'hFFFC;
        exp_single = 2;
        exp_double = 1;
        for (int i = 4; i < NUM_MSG; i++) begin
            n = $urandom_range(0, 2);
            dec_words[i] = inject(ref_encode($urandom_range(0, 2047)), n);
            if (n == 1) exp_single++;
            if (n == 2) exp_double++;
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            load(8'(8'h20 + 2 * i), dec_words[i][7:0]);
            load(8'(8'h21 + 2 * i), dec_words[i][15:8]);
        end
        do_run(1'b1, 8'h20, 8'h60, 0, cyc);
        n_cmp++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL dec_ack_latency: got %0d want 76", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({mem[8'(8'h61 + 2 * i)], mem[8'(8'h60 + 2 * i)]} !== {hi_want[i], 8'hFF}) begin
                n_fail++;
                $display("FAIL dec_vector%0d: got %h want %h", i,
                         {mem[8'(8'h61 + 2 * i)], mem[8'(8'h60 + 2 * i)]}, {hi_want[i], 8'hFF});
            end
        end
        check_decoded("dec", 8'h60);
    endtask

    task automatic test_start_ignored;
        int cyc;
        do_run(1'b1, 8'h20, 8'hA0, 10, cyc);
        n_cmp++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d want 76", cyc);
        end
        check_decoded("busy_start", 8'hA0);
    endtask

    task automatic test_back_to_back;
        int cyc;
        Mode    = 1'b1;
        SrcBase = 8'h20;
        DstBase = 8'hC0;
        Start   = 1'b1;
        tick();
        cyc = 1;
        while (!Ack && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc !== 76 || SingleCnt !== 4'(exp_single)) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d cycles single %0d want 76 single %0d", cyc, SingleCnt, exp_single);
        end
        tick();
        n_cmp++;
        if ({Ack, Busy, SingleCnt, DoubleCnt} !== 10'b01_0000_0000) begin
            n_fail++;
            $display("FAIL b2b_restart: got ack %b busy %b cnt %0d/%0d want 0 1 0/0", Ack, Busy, SingleCnt, DoubleCnt);
        end
        Start = 1'b0;
        cyc = 1;
        while (!Ack && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got %0d want 76", cyc);
        end
        check_decoded("b2b", 8'hC0);
    endtask

    task automatic test_inplace;
        logic [7:0] bg [256];
        int cyc;
        int bad;
        int off;
        int n;
        exp_single = 0;
        exp_double = 0;
        for (int a = 0; a < 256; a++) begin
            bg[a] = 8'($urandom);
            load(8'(a), bg[a]);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            n = $urandom_range(0, 2);
            dec_words[i] = inject(ref_encode($urandom_range(0, 2047)), n);
            if (n == 1) exp_single++;
            if (n == 2) exp_double++;
            load(8'(8'hFE + 2 * i), dec_words[i][7:0]);
            load(8'(8'hFF + 2 * i), dec_words[i][15:8]);
        end
        tb_clr = 1'b1;
        tick();
        tb_clr = 1'b0;
        do_run(1'b1, 8'hFE, 8'hFE, 0, cyc);
        n_cmp++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL inplace_latency: got %0d want 76", cyc);
        end
        check_decoded("inplace", 8'hFE);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            off = (a - 8'hFE) & 255;
            if (off < 2 * NUM_MSG) begin
                if (wcount[a] != 1) bad++;
            end else if (wcount[a] != 0 || mem[8'(a)] !== bg[a]) begin
                bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL inplace_footprint: got %0d bad bytes want 0", bad);
        end
    endtask

    task automatic test_reset_midrun;
        logic [15:0] raw [NUM_MSG];
        logic [15:0] e;
        int seen_we;
        int seen_ack;
        int untouched;
        for (int i = 0; i < NUM_MSG; i++) begin
            raw[i] = 16'($urandom);
            load(8'(8'h40 + 2 * i), raw[i][7:0]);
            load(8'(8'h41 + 2 * i), raw[i][15:8]);
            load(8'(8'h80 + 2 * i), 8'hA5);
            load(8'(8'h81 + 2 * i), 8'hA5);
        end
        Mode    = 1'b0;
        SrcBase = 8'h40;
        DstBase = 8'h80;
        Start   = 1'b1;
        tick();
        Start = 1'b0;
        repeat (17) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({Ack, Busy, MemWe} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_reset_ctrl: got %b want 000", {Ack, Busy, MemWe});
        end
        seen_we  = 0;
        seen_ack = 0;
        repeat (20) begin
            tick();
            if (MemWe) seen_we++;
            if (Ack) seen_ack++;
        end
        n_cmp++;
        if (seen_we !== 0 || seen_ack !== 0) begin
            n_fail++;
            $display("FAIL midrun_quiet: got we %0d ack %0d want 0 0", seen_we, seen_ack);
        end
        for (int i = 0; i < 3; i++) begin
            e = ref_encode(int'(raw[i] & 16'h07FF));
            n_cmp++;
            if ({mem[8'(8'h81 + 2 * i)], mem[8'(8'h80 + 2 * i)]} !== e) begin
                n_fail++;
                $display("FAIL midrun_rec%0d: got %h want %h", i, {mem[8'(8'h81 + 2 * i)], mem[8'(8'h80 + 2 * i)]}, e);
            end
        end
        untouched = 0;
        for (int a = 8'h86; a < 8'h80 + 2 * NUM_MSG; a++) if (mem[8'(a)] === 8'hA5) untouched++;
        n_cmp++;
        if (untouched !== 2 * NUM_MSG - 6) begin
            n_fail++;
            $display("FAIL midrun_no_late_writes: got %0d untouched want %0d", untouched, 2 * NUM_MSG - 6);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_decode();
        test_start_ignored();
        test_back_to_back();
        test_inplace();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
